// File: rtl/haraka_s_sequencer.sv
// Haraka-S sequencer: loads a 512-bit block into the permutation core, recirculates it for
// ROUNDS*ROUND_LAT clocks, then emits the feed-forward truncated 256-bit digest.
// Optional HARAKA_SEQ_PERF_EN adds the saturating hash_cnt digest counter output.
module haraka_s_sequencer #(
    parameter int unsigned ROUNDS    = 5,
    parameter int unsigned ROUND_LAT = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_data,
    output logic [511:0] core_in,
    output logic         core_sel,
    input  logic [511:0] core_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_data,
`ifdef HARAKA_SEQ_PERF_EN
    output logic [31:0]  hash_cnt,
`endif
    output logic         busy
);

    localparam int unsigned TOTAL = ROUNDS * ROUND_LAT;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);

    generate
        if (ROUNDS < 1 || ROUND_LAT < 1 || 64'(TOTAL) >= (64'd1 << CNT_W)) begin : g_bad_cfg
            $error("haraka_s_sequencer: ROUNDS*ROUND_LAT must be >=1 and fit in CNT_W bits");
        end
    endgenerate

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [511:0]     msg_q;
    logic [511:0]     ff;
    logic             unused_ff;

    assign ff        = core_out ^ msg_q;
    assign unused_ff = ^{ff[447:384], ff[319:256], ff[191:128], ff[63:0]};

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_LOAD) || (state == S_RUN);
    assign core_sel  = (state == S_RUN);
    assign out_valid = (state == S_DONE);
    assign core_in   = msg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            msg_q    <= '0;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        msg_q <= in_data;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= CNT_W'(1);
                    state <= S_RUN;
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    // >= rather than == so a single-clock schedule (TOTAL==1) still exits
                    if (cnt >= CNT_LAST) begin
                        state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    cnt      <= '0;
                    out_data <= {ff[511:448], ff[383:320], ff[255:192], ff[127:64]};
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HARAKA_SEQ_PERF_EN
    logic [31:0] hash_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_cnt_q <= '0;
        end else if (out_valid && out_ready && (hash_cnt_q != '1)) begin
            hash_cnt_q <= hash_cnt_q + 32'd1;
        end
    end

    assign hash_cnt = hash_cnt_q;
`endif

endmodule

// File: tb/tb_haraka_s_sequencer.sv
// Directed/randomized bench for haraka_s_sequencer with a stub core where perm(x) = ~swap_halves(x).
// Define HARAKA_SEQ_PERF_EN to also exercise the hash_cnt counter.
module tb_haraka_s_sequencer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_data;
    logic [511:0] core_in;
    logic         core_sel;
    logic [511:0] core_out;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         busy;
`ifdef HARAKA_SEQ_PERF_EN
    logic [31:0]  hash_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    haraka_s_sequencer #(.ROUNDS(5), .ROUND_LAT(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .core_in   (core_in),
        .core_sel  (core_sel),
        .core_out  (core_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef HARAKA_SEQ_PERF_EN
        .hash_cnt  (hash_cnt),
`endif
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub core: two-clock pipeline, zero output while recirculating
    logic [511:0] d1 = '0;
    logic [511:0] d2 = '0;
    always @(posedge clk) begin
        d1 <= core_in;
        d2 <= d1;
    end
    assign core_out = core_sel ? '0 : ~{d2[255:0], d2[511:256]};

    function automatic logic [255:0] ref_digest(input logic [511:0] m);
        logic [511:0] perm;
        logic [511:0] fwd;
        logic [63:0]  w [8];
        perm = ~{m[255:0], m[511:256]};
        fwd  = perm ^ m;
        for (int i = 0; i < 8; i++) w[i] = fwd[i*64 +: 64];
        return {w[7], w[5], w[3], w[1]};
    endfunction

    function automatic logic [511:0] rand_msg();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge with the DUT in IDLE
    task automatic run_block(input logic [511:0] msg, input int hold, input bit poke,
                             input bit chain, input logic [511:0] nxt);
        int cyc;
        int ones;
        int n;
        logic [255:0] exp;
        exp      = ref_digest(msg);
        in_data  = msg;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hs_wait", 512'(n), 512'(0));
        @(posedge clk);
        #1;
        if (poke) begin
            in_data   = rand_msg();
            out_ready = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        cyc  = 0;
        ones = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (core_sel) ones++;
            if (cyc == 1) begin
                chk("load_sel", 512'(core_sel), 512'(0));
                chk("load_busy", 512'(busy), 512'(1));
                chk("load_ready", 512'(in_ready), 512'(0));
                chk("load_core_in", core_in, msg);
            end
            if (cyc == 11) chk("capt_sel", 512'(core_sel), 512'(0));
        end while (!out_valid && cyc < 40);
        chk("latency", 512'(cyc), 512'(12));
        chk("sel_ones", 512'(ones), 512'(9));
        chk("digest", 512'(out_data), 512'(exp));
        chk("done_ready", 512'(in_ready), 512'(0));
        chk("done_busy", 512'(busy), 512'(0));
        in_valid = 1'b0;
        if (!poke) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", 512'(out_valid), 512'(1));
                chk("hold_data", 512'(out_data), 512'(exp));
                chk("hold_ready", 512'(in_ready), 512'(0));
            end
        end
        out_ready = 1'b1;
        if (chain) begin
            in_valid = 1'b1;
            in_data  = nxt;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", 512'(out_valid), 512'(0));
        chk("post_ready", 512'(in_ready), 512'(1));
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [511:0] cur;
        logic [511:0] nxt;
        int bad;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        @(negedge clk);
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_core_sel", 512'(core_sel), 512'(0));
        chk("rst_core_in", core_in, 512'(0));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_data", 512'(out_data), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        apply_reset();

        // all-zero block -> all-ones digest
        run_block('0, 0, 1'b0, 1'b0, '0);
        chk("zero_digest", 512'(out_data), 512'({256{1'b1}}));

        // long consumer stall, then back-to-back chain into a random block
        cur = rand_msg();
        run_block({8{64'h0123_4567_89AB_CDEF}}, 20, 1'b0, 1'b1, cur);
        nxt = rand_msg();
        run_block(cur, 0, 1'b0, 1'b1, nxt);
        run_block(nxt, 1, 1'b0, 1'b0, '0);

        // in_valid and out_ready held high during the run
        run_block(rand_msg(), 0, 1'b1, 1'b0, '0);

        cur = rand_msg();
        for (int i = 0; i < 6; i++) begin
            bit ch;
            nxt = rand_msg();
            ch  = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_block(cur, int'($urandom_range(0, 3)), 1'b0, ch, nxt);
            cur = nxt;
        end

        // reset in RUN at cnt=4
        in_data  = rand_msg();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_sel", 512'(core_sel), 512'(1));
        chk("pre_rst_cnt", 512'(dut.cnt), 512'(4));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 512'(core_sel), 512'(0));
        chk("mid_rst_busy", 512'(busy), 512'(0));
        chk("mid_rst_ready", 512'(in_ready), 512'(1));
        chk("mid_rst_valid", 512'(out_valid), 512'(0));
        chk("mid_rst_core_in", core_in, 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || busy) bad++;
        end
        chk("post_rst_quiet", 512'(bad), 512'(0));
        run_block(rand_msg(), 2, 1'b0, 1'b0, '0);

`ifdef HARAKA_SEQ_PERF_EN
        apply_reset();
        chk("perf_rst", 512'(hash_cnt), 512'(0));
        for (int i = 0; i < 3; i++) run_block(rand_msg(), 0, 1'b0, 1'b0, '0);
        chk("perf_three", 512'(hash_cnt), 512'(3));
        force dut.hash_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hash_cnt_q;
        run_block(rand_msg(), 0, 1'b0, 1'b0, '0);
        chk("perf_sat", 512'(hash_cnt), 512'(32'hFFFF_FFFF));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
